// File: rtl/conv_pkg.sv
// Shared types and width helpers for the strided convolution engine.
package conv_pkg;

  typedef enum logic [2:0] {IDLE, INIT, MAC, DRAIN, PUSH, DONE} state_t;
  typedef enum logic [1:0] {LD_FIRST, LD_W, LD_B, LD_X} ld_t;

  localparam int DRAIN_CYCLES = 2;
  localparam int MEM_LAT      = 1;

  // Worst case: MAXK*MAXK full-scale products plus a full-scale bias.
  function automatic int calc_outw(input int inw, input int maxk);
    longint v;
    v = (longint'(maxk * maxk) << (2 * inw - 2)) + (longint'(1) << (inw - 1));
    return $clog2(v) + 1;
  endfunction

  function automatic int calc_kbits(input int maxk);
    return $clog2(maxk + 1);
  endfunction

  function automatic int calc_sbits(input int maxs);
    return $clog2(maxs + 1);
  endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Nested output-pixel / kernel-tap counters producing X and W read addresses.
module conv_addr_gen
  import conv_pkg::*;
#(
  parameter int R    = 8,
  parameter int C    = 8,
  parameter int MAXK = 5,
  parameter int MAXS = 4,
  localparam int K_BITS = calc_kbits(MAXK),
  localparam int S_BITS = calc_sbits(MAXS),
  localparam int XA_W   = $clog2(R * C),
  localparam int WA_W   = $clog2(MAXK * MAXK)
)(
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_job_start,
  input  logic              i_tap_clr,
  input  logic              i_tap_en,
  input  logic              i_pix_adv,
  input  logic [K_BITS-1:0] i_k,
  input  logic [S_BITS-1:0] i_s,
  output logic [XA_W-1:0]   o_xaddr,
  output logic [WA_W-1:0]   o_waddr,
  output logic              o_last_tap,
  output logic              o_last_pixel
);
  localparam int RW   = $clog2(R);
  localparam int CW   = $clog2(C);
  localparam int SUMW = $clog2(R + C + MAXK + MAXS) + 1;

  logic [RW-1:0]     r_rb;
  logic [CW-1:0]     r_cb;
  logic [K_BITS-1:0] r_i, r_j;
  logic [K_BITS-1:0] w_klast;
  logic              w_last_col, w_last_row;

  assign w_klast = i_k - K_BITS'(1);
  // A window is the last in its row/column when the next stride step would overrun the image.
  assign w_last_col = (SUMW'(r_cb) + SUMW'(i_s) + SUMW'(i_k)) > SUMW'(C);
  assign w_last_row = (SUMW'(r_rb) + SUMW'(i_s) + SUMW'(i_k)) > SUMW'(R);

  assign o_last_tap   = (r_i == w_klast) && (r_j == w_klast);
  assign o_last_pixel = w_last_col && w_last_row;
  assign o_xaddr = (XA_W'(r_rb) + XA_W'(r_i)) * XA_W'(C) + XA_W'(r_cb) + XA_W'(r_j);
  assign o_waddr = WA_W'(r_i) * WA_W'(i_k) + WA_W'(r_j);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_i  <= '0;
      r_j  <= '0;
      r_rb <= '0;
      r_cb <= '0;
    end else begin
      if (i_tap_clr) begin
        r_i <= '0;
        r_j <= '0;
      end else if (i_tap_en) begin
        if (r_j == w_klast) begin
          r_j <= '0;
          r_i <= r_i + K_BITS'(1);
        end else begin
          r_j <= r_j + K_BITS'(1);
        end
      end
      if (i_job_start) begin
        r_rb <= '0;
        r_cb <= '0;
      end else if (i_pix_adv) begin
        if (w_last_col) begin
          r_cb <= '0;
          r_rb <= r_rb + RW'(i_s);
        end else begin
          r_cb <= r_cb + CW'(i_s);
        end
      end
    end
  end

endmodule

// File: rtl/conv_stride_relu.sv
// Strided 2D convolution with optional ReLU: stream loader, one MAC lane, job FSM, TLAST-tagged output fifo.
module conv_stride_relu
  import conv_pkg::*;
#(
  parameter int INW  = 18,
  parameter int R    = 8,
  parameter int C    = 8,
  parameter int MAXK = 5,
  parameter int MAXS = 4,
  localparam int OUTW   = calc_outw(INW, MAXK),
  localparam int K_BITS = calc_kbits(MAXK),
  localparam int S_BITS = calc_sbits(MAXS)
)(
  input  logic                   clk,
  input  logic                   reset,
  input  logic signed [INW-1:0]  INPUT_TDATA,
  input  logic                   INPUT_TVALID,
  input  logic [K_BITS:0]        INPUT_TUSER,
  output logic                   INPUT_TREADY,
  input  logic [S_BITS-1:0]      CFG_STRIDE,
  input  logic                   CFG_RELU,
  output logic signed [OUTW-1:0] OUTPUT_TDATA,
  output logic                   OUTPUT_TVALID,
  output logic                   OUTPUT_TLAST,
  input  logic                   OUTPUT_TREADY,
  output logic                   BUSY
);
  localparam int XA_W = $clog2(R * C);
  localparam int WA_W = $clog2(MAXK * MAXK);
  localparam int FD   = R * C;
  localparam int FA   = $clog2(FD);

  function automatic logic signed [OUTW-1:0] sext_in(input logic signed [INW-1:0] v);
    return {{(OUTW-INW){v[INW-1]}}, v};
  endfunction

  function automatic logic signed [OUTW-1:0] sext_prod(input logic signed [2*INW-1:0] v);
    return {{(OUTW-2*INW){v[2*INW-1]}}, v};
  endfunction

  function automatic logic signed [OUTW-1:0] relu_f(input logic signed [OUTW-1:0] v, input logic en);
    return (en && v < 0) ? '0 : v;
  endfunction

  ld_t                  r_ld;
  logic [XA_W-1:0]      r_ld_cnt;
  logic                 r_loaded;
  logic [K_BITS-1:0]    r_kin;
  logic [2*K_BITS-1:0]  w_kk_in;
  logic                 w_in_fire;
  logic signed [INW-1:0] r_xmem [R*C];
  logic signed [INW-1:0] r_wmem [MAXK*MAXK];
  logic signed [INW-1:0] r_bias;

  state_t               r_state, w_next;
  logic [1:0]           r_drain;
  logic [K_BITS-1:0]    r_k_l;
  logic [S_BITS-1:0]    r_s_l, w_s_legal;
  logic                 r_relu_l;
  logic                 w_job_start, w_push, w_pop;
  logic [XA_W-1:0]      w_xaddr;
  logic [WA_W-1:0]      w_waddr;
  logic                 w_last_tap, w_last_pixel;

  logic                    r_vld_p0, r_vld_p1;
  logic signed [INW-1:0]   r_x_p0, r_w_p0;
  logic signed [2*INW-1:0] r_prod_p1;
  logic signed [OUTW-1:0]  r_acc_p2;

  logic [OUTW:0]        r_fifo [FD];
  logic [FA-1:0]        r_wr, r_rd;
  logic [FA:0]          r_fcnt;

  // Stream loader: first word selects new weights (W, B, X) or X-only reuse.
  assign w_kk_in      = r_kin * r_kin;
  assign INPUT_TREADY = reset && !r_loaded;
  assign w_in_fire    = INPUT_TVALID && INPUT_TREADY;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ld     <= LD_FIRST;
      r_ld_cnt <= '0;
      r_loaded <= 1'b0;
      r_kin    <= '0;
    end else begin
      if (r_state == DONE) r_loaded <= 1'b0;
      if (w_in_fire) begin
        case (r_ld)
          LD_FIRST: begin
            r_ld_cnt <= XA_W'(1);
            if (INPUT_TUSER[0]) begin
              r_kin <= INPUT_TUSER[K_BITS:1];
              r_ld  <= (INPUT_TUSER[K_BITS:1] == K_BITS'(1)) ? LD_B : LD_W;
            end else begin
              r_ld  <= LD_X;
            end
          end
          LD_W: begin
            if (r_ld_cnt == XA_W'(w_kk_in) - XA_W'(1)) begin
              r_ld     <= LD_B;
              r_ld_cnt <= '0;
            end else begin
              r_ld_cnt <= r_ld_cnt + XA_W'(1);
            end
          end
          LD_B: begin
            r_ld     <= LD_X;
            r_ld_cnt <= '0;
          end
          default: begin
            if (r_ld_cnt == XA_W'(R * C - 1)) begin
              r_ld     <= LD_FIRST;
              r_ld_cnt <= '0;
              r_loaded <= 1'b1;
            end else begin
              r_ld_cnt <= r_ld_cnt + XA_W'(1);
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      case (r_ld)
        LD_FIRST: if (INPUT_TUSER[0]) r_wmem[0] <= INPUT_TDATA;
                  else r_xmem[0] <= INPUT_TDATA;
        LD_W:     r_wmem[WA_W'(r_ld_cnt)] <= INPUT_TDATA;
        LD_B:     r_bias <= INPUT_TDATA;
        default:  r_xmem[r_ld_cnt] <= INPUT_TDATA;
      endcase
    end
  end

  assign w_s_legal   = (CFG_STRIDE == '0 || CFG_STRIDE > S_BITS'(MAXS)) ? S_BITS'(1) : CFG_STRIDE;
  assign w_job_start = (r_state == IDLE) && r_loaded;
  assign w_push      = (r_state == PUSH) && (r_fcnt != (FA+1)'(FD));
  assign w_pop       = OUTPUT_TVALID && OUTPUT_TREADY;
  assign BUSY        = (r_state != IDLE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (r_loaded) w_next = INIT;
      INIT:    w_next = MAC;
      MAC:     if (w_last_tap) w_next = DRAIN;
      DRAIN:   if (r_drain == 2'(DRAIN_CYCLES - 1)) w_next = PUSH;
      PUSH:    if (w_push) w_next = w_last_pixel ? DONE : INIT;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_drain  <= '0;
      r_k_l    <= '0;
      r_s_l    <= S_BITS'(1);
      r_relu_l <= 1'b0;
      r_vld_p0 <= 1'b0;
      r_vld_p1 <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_drain  <= (r_state == DRAIN) ? r_drain + 2'd1 : 2'd0;
      if (w_job_start) begin
        r_k_l    <= r_kin;
        r_s_l    <= w_s_legal;
        r_relu_l <= CFG_RELU;
      end
      r_vld_p0 <= (r_state == MAC);
      r_vld_p1 <= r_vld_p0;
    end
  end

  conv_addr_gen #(.R(R), .C(C), .MAXK(MAXK), .MAXS(MAXS)) u_addr (
    .clk          (clk),
    .i_rst_n      (reset),
    .i_job_start  (w_job_start),
    .i_tap_clr    (r_state == INIT),
    .i_tap_en     (r_state == MAC),
    .i_pix_adv    (w_push),
    .i_k          (r_k_l),
    .i_s          (r_s_l),
    .o_xaddr      (w_xaddr),
    .o_waddr      (w_waddr),
    .o_last_tap   (w_last_tap),
    .o_last_pixel (w_last_pixel)
  );

  // p0: memory read; p1: product; p2: accumulate (bias preloaded in INIT)
  always_ff @(posedge clk) begin
    r_x_p0    <= r_xmem[w_xaddr];
    r_w_p0    <= r_wmem[w_waddr];
    r_prod_p1 <= r_x_p0 * r_w_p0;
    if (r_state == INIT)  r_acc_p2 <= sext_in(r_bias);
    else if (r_vld_p1)    r_acc_p2 <= r_acc_p2 + sext_prod(r_prod_p1);
  end

  // Output fifo holds one whole image, TLAST stored as the top bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_fcnt <= '0;
    end else begin
      if (w_push) r_wr <= (r_wr == FA'(FD - 1)) ? '0 : r_wr + FA'(1);
      if (w_pop)  r_rd <= (r_rd == FA'(FD - 1)) ? '0 : r_rd + FA'(1);
      if (w_push && !w_pop)      r_fcnt <= r_fcnt + (FA+1)'(1);
      else if (!w_push && w_pop) r_fcnt <= r_fcnt - (FA+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr] <= {w_last_pixel, relu_f(r_acc_p2, r_relu_l)};
  end

  assign OUTPUT_TVALID = (r_fcnt != '0);
  assign OUTPUT_TDATA  = r_fifo[r_rd][OUTW-1:0];
  assign OUTPUT_TLAST  = OUTPUT_TVALID && r_fifo[r_rd][OUTW];

endmodule

// File: tb/tb_conv_stride_relu.sv
// Directed bench for conv_stride_relu: stride, ReLU, TLAST, backpressure and mid-job reset.
module tb_conv_stride_relu;
  import conv_pkg::*;

  localparam int INW  = 18;
  localparam int R    = 8;
  localparam int C    = 8;
  localparam int MAXK = 5;
  localparam int MAXS = 4;
  localparam int OUTW = calc_outw(INW, MAXK);
  localparam int KB   = calc_kbits(MAXK);
  localparam int SB   = calc_sbits(MAXS);

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic signed [INW-1:0]  INPUT_TDATA = '0;
  logic                   INPUT_TVALID = 1'b0;
  logic [KB:0]            INPUT_TUSER = '0;
  logic                   INPUT_TREADY;
  logic [SB-1:0]          CFG_STRIDE = SB'(1);
  logic                   CFG_RELU = 1'b0;
  logic signed [OUTW-1:0] OUTPUT_TDATA;
  logic                   OUTPUT_TVALID;
  logic                   OUTPUT_TLAST;
  logic                   OUTPUT_TREADY = 1'b1;
  logic                   BUSY;

  int n_chk  = 0;
  int n_fail = 0;
  int wv [25];
  int xv [64];
  logic [OUTW:0] q [$];

  conv_stride_relu #(.INW(INW), .R(R), .C(C), .MAXK(MAXK), .MAXS(MAXS)) dut (
    .clk           (clk),
    .reset         (reset),
    .INPUT_TDATA   (INPUT_TDATA),
    .INPUT_TVALID  (INPUT_TVALID),
    .INPUT_TUSER   (INPUT_TUSER),
    .INPUT_TREADY  (INPUT_TREADY),
    .CFG_STRIDE    (CFG_STRIDE),
    .CFG_RELU      (CFG_RELU),
    .OUTPUT_TDATA  (OUTPUT_TDATA),
    .OUTPUT_TVALID (OUTPUT_TVALID),
    .OUTPUT_TLAST  (OUTPUT_TLAST),
    .OUTPUT_TREADY (OUTPUT_TREADY),
    .BUSY          (BUSY)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (reset && OUTPUT_TVALID && OUTPUT_TREADY) q.push_back({OUTPUT_TLAST, OUTPUT_TDATA});

  task automatic send_word(input int d, input logic [KB:0] u);
    int n;
    INPUT_TDATA  = INW'(d);
    INPUT_TUSER  = u;
    INPUT_TVALID = 1'b1;
    n = 0;
    while (!INPUT_TREADY && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!INPUT_TREADY) begin
      n_chk++;
      n_fail++;
      $display("FAIL input_handshake ready=0 required=1");
    end
    @(negedge clk);
    INPUT_TVALID = 1'b0;
  endtask

  task automatic load_image(input int k, input int b, input int s, input logic relu);
    CFG_STRIDE = SB'(s);
    CFG_RELU   = relu;
    send_word(wv[0], {KB'(k), 1'b1});
    for (int t = 1; t < k * k; t++) send_word(wv[t], '0);
    send_word(b, '0);
    for (int t = 0; t < R * C; t++) send_word(xv[t], '0);
  endtask

  task automatic wait_outs(input int n);
    int cyc;
    cyc = 0;
    while (q.size() < n && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (30) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_chk++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
    n_chk++; if (OUTPUT_TVALID !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid got=%b exp=0", OUTPUT_TVALID); end
    n_chk++; if (OUTPUT_TLAST !== 1'b0) begin n_fail++; $display("FAIL reset_tlast got=%b exp=0", OUTPUT_TLAST); end
    n_chk++; if (INPUT_TREADY !== 1'b0) begin n_fail++; $display("FAIL reset_tready got=%b exp=0", INPUT_TREADY); end
    reset = 1'b1;
    @(negedge clk);
    n_chk++; if (INPUT_TREADY !== 1'b1) begin n_fail++; $display("FAIL idle_tready got=%b exp=1", INPUT_TREADY); end
  endtask

  task automatic test_ones();
    logic [OUTW-1:0] e;
    q.delete();
    for (int t = 0; t < 25; t++) wv[t] = 1;
    for (int t = 0; t < 64; t++) xv[t] = 1;
    load_image(3, 0, 1, 1'b0);
    @(negedge clk);
    n_chk++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL ones_busy got=%b exp=1", BUSY); end
    n_chk++; if (INPUT_TREADY !== 1'b0) begin n_fail++; $display("FAIL ones_tready_busy got=%b exp=0", INPUT_TREADY); end
    wait_outs(36);
    n_chk++; if (q.size() != 36) begin n_fail++; $display("FAIL ones_count got=%0d exp=36", q.size()); end
    for (int p = 0; p < 36 && p < q.size(); p++) begin
      e = OUTW'(9);
      n_chk++;
      if (q[p][OUTW-1:0] !== e || q[p][OUTW] !== (p == 35)) begin
        n_fail++;
        $display("FAIL ones_pix%0d got=%0d/last%b exp=%0d/last%b", p, $signed(q[p][OUTW-1:0]), q[p][OUTW], $signed(e), (p == 35));
      end
    end
    n_chk++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL ones_busy_end got=%b exp=0", BUSY); end
  endtask

  task automatic test_stride2();
    logic [OUTW-1:0] e;
    q.delete();
    for (int t = 0; t < 25; t++) wv[t] = (t == 4) ? 1 : 0;
    for (int t = 0; t < 64; t++) xv[t] = t;
    load_image(3, 0, 2, 1'b0);
    wait_outs(9);
    n_chk++; if (q.size() != 9) begin n_fail++; $display("FAIL s2_count got=%0d exp=9", q.size()); end
    for (int p = 0; p < 9 && p < q.size(); p++) begin
      e = OUTW'((2 * (p / 3) + 1) * 8 + 2 * (p % 3) + 1);
      n_chk++;
      if (q[p][OUTW-1:0] !== e || q[p][OUTW] !== (p == 8)) begin
        n_fail++;
        $display("FAIL s2_pix%0d got=%0d/last%b exp=%0d/last%b", p, $signed(q[p][OUTW-1:0]), q[p][OUTW], $signed(e), (p == 8));
      end
    end
  endtask

  task automatic test_relu();
    logic [OUTW-1:0] e;
    for (int pass = 0; pass < 2; pass++) begin
      q.delete();
      for (int t = 0; t < 25; t++) wv[t] = -1;
      for (int t = 0; t < 64; t++) xv[t] = 1;
      load_image(3, 2, 1, (pass == 0));
      wait_outs(36);
      e = (pass == 0) ? OUTW'(0) : OUTW'(-7);
      n_chk++; if (q.size() != 36) begin n_fail++; $display("FAIL relu%0d_count got=%0d exp=36", pass, q.size()); end
      for (int p = 0; p < 36 && p < q.size(); p++) begin
        n_chk++;
        if (q[p][OUTW-1:0] !== e || q[p][OUTW] !== (p == 35)) begin
          n_fail++;
          $display("FAIL relu%0d_pix%0d got=%0d/last%b exp=%0d", pass, p, $signed(q[p][OUTW-1:0]), q[p][OUTW], $signed(e));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [OUTW-1:0] e;
    int cyc, held, nlast;
    q.delete();
    for (int t = 0; t < 25; t++) wv[t] = 1;
    for (int t = 0; t < 64; t++) xv[t] = t;
    load_image(3, 0, 1, 1'b0);
    cyc = 0;
    while (q.size() < 10 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    @(posedge clk);
    #1 OUTPUT_TREADY = 1'b0;
    held = q.size();
    repeat (50) @(negedge clk);
    n_chk++; if (q.size() != held) begin n_fail++; $display("FAIL bp_hold got=%0d exp=%0d", q.size(), held); end
    n_chk++; if (OUTPUT_TVALID !== 1'b1) begin n_fail++; $display("FAIL bp_tvalid got=%b exp=1", OUTPUT_TVALID); end
    @(posedge clk);
    #1 OUTPUT_TREADY = 1'b1;
    wait_outs(36);
    n_chk++; if (q.size() != 36) begin n_fail++; $display("FAIL bp_count got=%0d exp=36", q.size()); end
    nlast = 0;
    for (int p = 0; p < 36 && p < q.size(); p++) begin
      e = OUTW'(72 * (p / 6) + 9 * (p % 6) + 81);
      if (q[p][OUTW]) nlast++;
      n_chk++;
      if (q[p][OUTW-1:0] !== e) begin
        n_fail++;
        $display("FAIL bp_pix%0d got=%0d exp=%0d", p, $signed(q[p][OUTW-1:0]), $signed(e));
      end
    end
    n_chk++; if (nlast != 1 || (q.size() == 36 && q[35][OUTW] !== 1'b1)) begin n_fail++; $display("FAIL bp_tlast got=%0d exp=1", nlast); end
  endtask

  task automatic test_k5();
    logic [OUTW-1:0] e;
    q.delete();
    for (int t = 0; t < 25; t++) wv[t] = (t == 12) ? 1 : 0;
    for (int t = 0; t < 64; t++) xv[t] = t;
    load_image(5, 0, 3, 1'b0);
    wait_outs(4);
    n_chk++; if (q.size() != 4) begin n_fail++; $display("FAIL k5s3_count got=%0d exp=4", q.size()); end
    for (int p = 0; p < 4 && p < q.size(); p++) begin
      e = OUTW'((3 * (p / 2) + 2) * 8 + 3 * (p % 2) + 2);
      n_chk++;
      if (q[p][OUTW-1:0] !== e || q[p][OUTW] !== (p == 3)) begin
        n_fail++;
        $display("FAIL k5s3_pix%0d got=%0d/last%b exp=%0d", p, $signed(q[p][OUTW-1:0]), q[p][OUTW], $signed(e));
      end
    end
    q.delete();
    load_image(5, 0, 0, 1'b0);
    wait_outs(16);
    n_chk++; if (q.size() != 16) begin n_fail++; $display("FAIL k5s0_count got=%0d exp=16", q.size()); end
    for (int p = 0; p < 16 && p < q.size(); p++) begin
      e = OUTW'(((p / 4) + 2) * 8 + (p % 4) + 2);
      n_chk++;
      if (q[p][OUTW-1:0] !== e || q[p][OUTW] !== (p == 15)) begin
        n_fail++;
        $display("FAIL k5s0_pix%0d got=%0d/last%b exp=%0d", p, $signed(q[p][OUTW-1:0]), q[p][OUTW], $signed(e));
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic [OUTW-1:0] e;
    q.delete();
    for (int t = 0; t < 25; t++) wv[t] = 1;
    for (int t = 0; t < 64; t++) xv[t] = 1;
    load_image(3, 0, 1, 1'b0);
    cyc = 0;
    while (q.size() < 9 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    n_chk++; if (OUTPUT_TVALID !== 1'b0) begin n_fail++; $display("FAIL midrst_tvalid got=%b exp=0", OUTPUT_TVALID); end
    n_chk++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", BUSY); end
    n_chk++; if (OUTPUT_TLAST !== 1'b0) begin n_fail++; $display("FAIL midrst_tlast got=%b exp=0", OUTPUT_TLAST); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    q.delete();
    @(negedge clk);
    load_image(3, 0, 1, 1'b0);
    wait_outs(36);
    n_chk++; if (q.size() != 36) begin n_fail++; $display("FAIL midrst_count got=%0d exp=36", q.size()); end
    for (int p = 0; p < 36 && p < q.size(); p++) begin
      e = OUTW'(9);
      n_chk++;
      if (q[p][OUTW-1:0] !== e || q[p][OUTW] !== (p == 35)) begin
        n_fail++;
        $display("FAIL midrst_pix%0d got=%0d/last%b exp=9", p, $signed(q[p][OUTW-1:0]), q[p][OUTW]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ones();
    test_stride2();
    test_relu();
    test_backpressure();
    test_k5();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_stride_relu.md
Name: conv_stride_relu

Overview:
Second-generation 2D convolution engine. It adds a runtime stride (1..MAXS), an optional ReLU on each output, OUTPUT_TLAST on the final pixel of each image, and stall-safe output backpressure. It sits between the AXI-Stream input loader (input_mems) and the output stream (fifo_out), and computes with one mac_pipe lane. The controller owns address generation, job sequencing and output gating.

Parameters:
INW, 18, signed input/weight/bias width
R, 8, input rows
C, 8, input columns
MAXK, 5, maximum kernel size
MAXS, 4, maximum stride
OUTW (localparam), clog2(MAXK*MAXK*2^(2*INW-2) + 2^(INW-1)) + 1, accumulator/output width
K_BITS (localparam), clog2(MAXK+1), kernel-size field width
S_BITS (localparam), clog2(MAXS+1), stride field width

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
INPUT_TDATA  input  INW  X/W/B/K stream data
INPUT_TVALID  input  1  input valid
INPUT_TUSER  input  K_BITS+1  K field plus new-W flag (input_mems format)
INPUT_TREADY  output  1  input ready
CFG_STRIDE  input  S_BITS  stride, latched at job start
CFG_RELU  input  1  1 = clamp negative outputs to 0; latched at job start
OUTPUT_TDATA  output  OUTW  signed result
OUTPUT_TVALID  output  1  output valid
OUTPUT_TLAST  output  1  high with the last pixel of an image
OUTPUT_TREADY  input  1  output ready
BUSY  output  1  high from job start until DONE completes

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; all counters 0; BUSY=0; OUTPUT_TVALID=0; OUTPUT_TLAST=0; INPUT_TREADY=0 while in reset. Reused submodules receive reset = ~reset.
- Config latch: on the IDLE->INIT transition (inputs_loaded=1), latch k_l=K, s_l=CFG_STRIDE, relu_l=CFG_RELU.
- Illegal stride: s_l=0 or s_l>MAXS is treated as 1.
- Output size: Rout=(R-k_l)/s_l+1, Cout=(C-k_l)/s_l+1, integer floor.
- Loop order: orow, then ocol, then i, then j. Pixel base address = (orow*s_l)*C + ocol*s_l. X address = base + i*C + j. W address = i*k_l + j.
- States:
  - IDLE: wait for inputs_loaded.
  - INIT: init_acc=1, load bias; issue address (0,0).
  - MAC: issue one (i,j) address per cycle. mac input_valid lags the address by 1 cycle (memory read latency 1). After k_l*k_l issues, go to DRAIN.
  - DRAIN: 2 cycles for the pipeline to flush.
  - PUSH: drive fifo IN_TVALID=1 with data = relu_l && acc<0 ? 0 : acc. Hold until IN_TREADY=1. The accumulator is not re-initialised while stalled. On accept, advance ocol/orow; go to INIT, or to DONE after the last pixel.
  - DONE: pulse compute_finished for 1 cycle, then IDLE.
- Latency per pixel with no stall: k_l*k_l + 4 cycles (INIT, MAC, DRAIN, PUSH).
- TLAST: stored as an extra bit alongside data in the fifo, set for pixel (Rout-1, Cout-1). The fifo width is therefore OUTW+1.
- Fifo DEPTH = Rout_max*Cout_max with K=1, S=1, i.e. R*C. This guarantees no overflow if the consumer stalls for a whole image.
- Simultaneous events: fifo pop and push in the same cycle are legal.
- Next-job overlap: a new image may load into input_mems while DONE→IDLE completes. CFG changes while BUSY=1 are ignored.
- Reset mid-job: immediate return to IDLE. The fifo is emptied and no partial TLAST is emitted.
- Arithmetic: two's-complement. Bias is sign-extended to OUTW. No saturation is needed because OUTW is sized for the worst case.

Decomposition:
- Package conv_pkg:
  - state_t enum: IDLE, INIT, MAC, DRAIN, PUSH, DONE.
  - OUTW/K_BITS/S_BITS calculation functions.
  - DRAIN_CYCLES=2.
  - MEM_LAT=1.
- Sub-module conv_addr_gen: nested orow/ocol/i/j counters with stride. Outputs X/W addresses, last_tap, last_pixel.
- Reuses input_mems, mac_pipe and fifo_out (fifo width parameterised to OUTW+1).

Test Plan:
- R=C=8, K=3, S=1, X=1, W=1, B=0, RELU=0 -> 36 outputs, each 9; TLAST only on the 36th.
- R=C=8, K=3, S=2, X[r][c]=r*8+c, W=center-only 1, B=0 -> 9 outputs, value at (or,oc) = (2*or+1)*8+(2*oc+1); first 9, last 45.
- K=3, S=1, all W=-1, X=1, B=2, RELU=1 -> 36 zeros. Same with RELU=0 -> 36 values of -7.
- OUTPUT_TREADY held 0 for 50 cycles mid-image, then 1 -> no loss or duplication; all 36 outputs in order; TLAST count =1.
- K=5, S=3 -> Rout=Cout=2, 4 outputs. CFG_STRIDE=0 -> behaves as S=1, 16 outputs.
- reset=0 during MAC of pixel 10 -> OUTPUT_TVALID=0 and BUSY=0 within the same cycle. A fresh image then produces a correct full result set.
